// File: rtl/mem_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin memory scheduler.
// Optional watchdog: MEM_SCHED_TIMEOUT_EN.
package mem_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_READ_WAITING   = 3'd1,
        S_WRITE_WAITING  = 3'd2,
        S_READ_RELAYING  = 3'd3,
        S_WRITE_RELAYING = 3'd4
    } sched_state_t;

    // State entered on reset.
    localparam sched_state_t RST_STATE = S_IDLE;
    // Reset level of every registered valid/ready/error flag.
    localparam logic RST_FLAG = 1'b0;
    // Search begins this many slots after the previous winner.
    localparam int RR_START = 1;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant.
// Optional watchdog in top: MEM_SCHED_TIMEOUT_EN.
module mem_rr_arbiter
    import mem_sched_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int IW            = $clog2(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] i_req,
    input  logic [IW-1:0]            i_last_grant,
    output logic [NUM_CONSUMERS-1:0] o_grant,
    output logic [IW-1:0]            o_grant_idx
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // Walk the ring from last_grant+RR_START; power-of-two size wraps freely.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            w_idx = i_last_grant + IW'(i + RR_START);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant_idx    = w_idx;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_rr_scheduler.sv
// Shares one memory channel among consumers with round-robin arbitration.
// Macro MEM_SCHED_TIMEOUT_EN compiles in the waiting-state watchdog.
module mem_rr_scheduler
    import mem_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int NUM_CONSUMERS  = 4,
    parameter int WRITE_ENABLE   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CONSUMERS-1:0]               consumer_read_valid,
    input  logic [ADDRESS_WIDTH*NUM_CONSUMERS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]               consumer_read_ready,
    output logic [DATA_WIDTH*NUM_CONSUMERS-1:0]    consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]               consumer_write_valid,
    input  logic [ADDRESS_WIDTH*NUM_CONSUMERS-1:0] consumer_write_address,
    input  logic [DATA_WIDTH*NUM_CONSUMERS-1:0]    consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]               consumer_write_ready,
    output logic [NUM_CONSUMERS-1:0]               consumer_error,
    output logic                                   mem_read_valid,
    output logic [ADDRESS_WIDTH-1:0]               mem_read_address,
    input  logic                                   mem_read_ready,
    input  logic [DATA_WIDTH-1:0]                  mem_read_data,
    output logic                                   mem_write_valid,
    output logic [ADDRESS_WIDTH-1:0]               mem_write_address,
    output logic [DATA_WIDTH-1:0]                  mem_write_data,
    input  logic                                   mem_write_ready,
    output logic                                   busy
);

    localparam int IW = $clog2(NUM_CONSUMERS);

    sched_state_t                 r_state;
    logic [IW-1:0]                r_last_grant;
    logic [IW-1:0]                r_idx;
    logic [NUM_CONSUMERS-1:0]     w_elig;
    logic [NUM_CONSUMERS-1:0]     w_grant;
    logic [IW-1:0]                w_gidx;
    logic                         w_is_read;

`ifdef MEM_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_cnt;
`else
    assign consumer_error = '0;
`endif

    // Writes only compete for the port when the write path is enabled.
    assign w_elig = consumer_read_valid
                  | ((WRITE_ENABLE != 0) ? consumer_write_valid : '0);
    assign w_is_read = |(w_grant & consumer_read_valid);
    assign busy = (r_state != S_IDLE);

    mem_rr_arbiter #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .IW            (IW)
    ) u_arb (
        .i_req        (w_elig),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_gidx)
    );

    // Scheduler FSM: grant, wait on memory, relay completion to consumer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state              <= RST_STATE;
            r_last_grant         <= IW'(NUM_CONSUMERS - RR_START);
            r_idx                <= '0;
            mem_read_valid       <= RST_FLAG;
            mem_write_valid      <= RST_FLAG;
            mem_read_address     <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '0;
`ifdef MEM_SCHED_TIMEOUT_EN
            consumer_error       <= '0;
            r_cnt                <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|w_elig) begin
                        r_last_grant <= w_gidx;
                        r_idx        <= w_gidx;
`ifdef MEM_SCHED_TIMEOUT_EN
                        r_cnt        <= '0;
`endif
                        if (w_is_read) begin
                            mem_read_address <= consumer_read_address[
                                w_gidx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                            mem_read_valid   <= 1'b1;
                            r_state          <= S_READ_WAITING;
                        end else begin
                            mem_write_address <= consumer_write_address[
                                w_gidx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                            mem_write_data    <= consumer_write_data[
                                w_gidx*DATA_WIDTH +: DATA_WIDTH];
                            mem_write_valid   <= 1'b1;
                            r_state           <= S_WRITE_WAITING;
                        end
                    end
                end
                S_READ_WAITING: begin
                    if (mem_read_ready) begin
                        mem_read_valid             <= 1'b0;
                        consumer_read_ready[r_idx] <= 1'b1;
                        consumer_read_data[r_idx*DATA_WIDTH +: DATA_WIDTH]
                            <= mem_read_data;
                        r_state                    <= S_READ_RELAYING;
                    end
`ifdef MEM_SCHED_TIMEOUT_EN
                    else if (r_cnt == T_LAST) begin
                        mem_read_valid             <= 1'b0;
                        consumer_read_ready[r_idx] <= 1'b1;
                        consumer_error[r_idx]      <= 1'b1;
                        consumer_read_data[r_idx*DATA_WIDTH +: DATA_WIDTH]
                            <= '0;
                        r_state                    <= S_READ_RELAYING;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_WRITE_WAITING: begin
                    if (mem_write_ready) begin
                        mem_write_valid             <= 1'b0;
                        consumer_write_ready[r_idx] <= 1'b1;
                        r_state                     <= S_WRITE_RELAYING;
                    end
`ifdef MEM_SCHED_TIMEOUT_EN
                    else if (r_cnt == T_LAST) begin
                        mem_write_valid             <= 1'b0;
                        consumer_write_ready[r_idx] <= 1'b1;
                        consumer_error[r_idx]       <= 1'b1;
                        r_state                     <= S_WRITE_RELAYING;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_READ_RELAYING: begin
                    if (!consumer_read_valid[r_idx]) begin
                        consumer_read_ready <= '0;
`ifdef MEM_SCHED_TIMEOUT_EN
                        consumer_error      <= '0;
`endif
                        r_state             <= S_IDLE;
                    end
                end
                S_WRITE_RELAYING: begin
                    if (!consumer_write_valid[r_idx]) begin
                        consumer_write_ready <= '0;
`ifdef MEM_SCHED_TIMEOUT_EN
                        consumer_error       <= '0;
`endif
                        r_state              <= S_IDLE;
                    end
                end
                default: begin
                    mem_read_valid       <= 1'b0;
                    mem_write_valid      <= 1'b0;
                    consumer_read_ready  <= '0;
                    consumer_write_ready <= '0;
                    r_state              <= S_IDLE;
                end
            endcase
        end
    end

endmodule
